// File: rtl/bus_regfile_if.sv
//------------------------------------------------------------------------------
// Module   : bus_regfile_if
// Purpose  : Control/status bundle between the control unit and bus_regfile.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bus_regfile_if #(
  parameter int NREGS = 4
);
  localparam int c_SW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic              ld_en;
  logic [c_SW-1:0]   ld_sel;
  logic              oe_en;
  logic [c_SW-1:0]   oe_sel;
  logic [NREGS-1:0]  clr;
  logic              mv_start;
  logic [c_SW-1:0]   mv_src;
  logic [c_SW-1:0]   mv_dst;
  logic              mv_busy;
  logic              mv_done;
  logic              req_err;
  logic              err_clr;

  modport master (
    output ld_en, ld_sel, oe_en, oe_sel, clr,
    output mv_start, mv_src, mv_dst, err_clr,
    input  mv_busy, mv_done, req_err
  );

  modport slave (
    input  ld_en, ld_sel, oe_en, oe_sel, clr,
    input  mv_start, mv_src, mv_dst, err_clr,
    output mv_busy, mv_done, req_err
  );
endinterface

`default_nettype wire

// File: rtl/bus_regfile.sv
//------------------------------------------------------------------------------
// Module   : bus_regfile
// Purpose  : NREGS x WIDTH register file on a tri-state bus with a move engine.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_regfile #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] bus,
  bus_regfile_if.slave     ctl
);

  localparam int c_SW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_LOAD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_hold;
  logic [c_SW-1:0]  r_dst;
  logic             r_src_ok;
  logic             r_dst_ok;
  logic             r_req_err;

  logic             w_idle;
  logic             w_busy;
  logic             w_accept;
  logic             w_oe_ok;
  logic             w_src_ok;
  logic             w_dst_ok;
  logic             w_mv_load;
  logic             w_drv_en;
  logic [WIDTH-1:0] w_drv_val;
  logic [WIDTH-1:0] w_oe_val;
  logic [WIDTH-1:0] w_src_val;

  assign w_idle    = (r_state == S_IDLE);
  assign w_busy    = (r_state == S_DRIVE) || (r_state == S_LOAD);
  assign w_oe_ok   = int'(ctl.oe_sel) < NREGS;
  assign w_src_ok  = int'(ctl.mv_src) < NREGS;
  assign w_dst_ok  = int'(ctl.mv_dst) < NREGS;
  assign w_mv_load = (r_state == S_LOAD) && r_src_ok && r_dst_ok;

  // Out-of-range selects match no index and fall through to zero
  always_comb begin
    w_oe_val  = '0;
    w_src_val = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (int'(ctl.oe_sel) == i) w_oe_val  = r_regs[i];
      if (int'(ctl.mv_src) == i) w_src_val = r_regs[i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (ctl.mv_start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_DRIVE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DRIVE: w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Reset gates the driver so the bus is released without waiting for an edge
  assign w_drv_en  = !reset && ((w_busy && r_src_ok) ||
                                (w_idle && ctl.oe_en && w_oe_ok));
  assign w_drv_val = w_busy ? r_hold : w_oe_val;
  assign bus       = w_drv_en ? w_drv_val : {WIDTH{1'bz}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_hold    <= '0;
      r_dst     <= '0;
      r_src_ok  <= 1'b0;
      r_dst_ok  <= 1'b0;
      r_req_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_hold   <= w_src_val;
        r_dst    <= ctl.mv_dst;
        r_src_ok <= w_src_ok;
        r_dst_ok <= w_dst_ok;
      end
      if (w_busy && (ctl.ld_en || ctl.oe_en || ctl.mv_start)) begin
        r_req_err <= 1'b1;
      end else if (ctl.err_clr) begin
        r_req_err <= 1'b0;
      end
    end
  end

  // Clear beats both load paths; move and direct loads never coincide
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (ctl.clr[i]) begin
          r_regs[i] <= '0;
        end else if (w_mv_load && (int'(r_dst) == i)) begin
          r_regs[i] <= bus;
        end else if (w_idle && ctl.ld_en && (int'(ctl.ld_sel) == i)) begin
          r_regs[i] <= bus;
        end
      end
    end
  end

  assign ctl.mv_busy = w_busy;
  assign ctl.mv_done = (r_state == S_DONE);
  assign ctl.req_err = r_req_err;

endmodule

`default_nettype wire

// File: tb/tb_bus_regfile.sv
//------------------------------------------------------------------------------
// Module   : tb_bus_regfile
// Purpose  : Directed self-checking bench for bus_regfile (8x4 and 16x3).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bus_regfile;

  logic        clk;
  logic        reset;
  wire  [7:0]  bus_a;
  wire  [15:0] bus_b;
  logic        drv_a;
  logic [7:0]  val_a;
  logic        drv_b;
  logic [15:0] val_b;
  int          n_checks;
  int          n_errors;

  bus_regfile_if #(.NREGS(4)) ia ();
  bus_regfile_if #(.NREGS(3)) ib ();

  bus_regfile #(.WIDTH(8), .NREGS(4)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a),
    .ctl   (ia)
  );

  bus_regfile #(.WIDTH(16), .NREGS(3)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b),
    .ctl   (ib)
  );

  assign bus_a = drv_a ? val_a : 8'hzz;
  assign bus_b = drv_b ? val_b : 16'hzzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // An undriven bus is reported as zero; test values are all non-zero
  function automatic logic [31:0] obs_a();
    return $isunknown(bus_a) ? 32'h0 : 32'(bus_a);
  endfunction

  function automatic logic [31:0] obs_b();
    return $isunknown(bus_b) ? 32'h0 : 32'(bus_b);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [1:0] sel, input logic [7:0] val);
    drv_a = 1'b1; val_a = val; ia.ld_en = 1'b1; ia.ld_sel = sel;
    step();
    drv_a = 1'b0; ia.ld_en = 1'b0;
  endtask

  task automatic read_a(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    ia.oe_en = 1'b1; ia.oe_sel = sel;
    #1;
    check(tag, obs_a(), 32'(exp));
    ia.oe_en = 1'b0;
    #1;
  endtask

  task automatic start_a(input logic [1:0] src, input logic [1:0] dst);
    ia.mv_start = 1'b1; ia.mv_src = src; ia.mv_dst = dst;
    step();
    ia.mv_start = 1'b0;
  endtask

  task automatic load_b(input logic [1:0] sel, input logic [15:0] val);
    drv_b = 1'b1; val_b = val; ib.ld_en = 1'b1; ib.ld_sel = sel;
    step();
    drv_b = 1'b0; ib.ld_en = 1'b0;
  endtask

  task automatic read_b(input string tag, input logic [1:0] sel, input logic [15:0] exp);
    ib.oe_en = 1'b1; ib.oe_sel = sel;
    #1;
    check(tag, obs_b(), 32'(exp));
    ib.oe_en = 1'b0;
    #1;
  endtask

  task automatic start_b(input logic [1:0] src, input logic [1:0] dst);
    ib.mv_start = 1'b1; ib.mv_src = src; ib.mv_dst = dst;
    step();
    ib.mv_start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    drv_a = 1'b0; val_a = '0; drv_b = 1'b0; val_b = '0;
    ia.ld_en = 0; ia.ld_sel = 0; ia.oe_en = 0; ia.oe_sel = 0; ia.clr = 0;
    ia.mv_start = 0; ia.mv_src = 0; ia.mv_dst = 0; ia.err_clr = 0;
    ib.ld_en = 0; ib.ld_sel = 0; ib.oe_en = 0; ib.oe_sel = 0; ib.clr = 0;
    ib.mv_start = 0; ib.mv_src = 0; ib.mv_dst = 0; ib.err_clr = 0;
    reset = 1'b1;
    step(); step();
    check("rst_busy", 32'(ia.mv_busy), 32'd0);
    check("rst_done", 32'(ia.mv_done), 32'd0);
    check("rst_err", 32'(ia.req_err), 32'd0);
    reset = 1'b0;

    // Direct load, output and one-cycle transfer
    load_a(2'd0, 8'hCD);
    read_a("direct_r0", 2'd0, 8'hCD);
    ia.oe_en = 1'b1; ia.oe_sel = 2'd0; ia.ld_en = 1'b1; ia.ld_sel = 2'd1;
    step();
    ia.oe_en = 1'b0; ia.ld_en = 1'b0;
    read_a("xfer_r1", 2'd1, 8'hCD);
    check("bus_release", obs_a(), 32'h0);

    // Basic move 2 -> 3
    load_a(2'd2, 8'h5A);
    load_a(2'd3, 8'h11);
    start_a(2'd2, 2'd3);
    check("mv_drive_busy", 32'(ia.mv_busy), 32'd1);
    check("mv_drive_done", 32'(ia.mv_done), 32'd0);
    check("mv_drive_bus", obs_a(), 32'h5A);
    step();
    check("mv_load_busy", 32'(ia.mv_busy), 32'd1);
    check("mv_load_bus", obs_a(), 32'h5A);
    step();
    check("mv_done_busy", 32'(ia.mv_busy), 32'd0);
    check("mv_done_pulse", 32'(ia.mv_done), 32'd1);
    check("mv_done_bus", obs_a(), 32'h0);
    step();
    check("mv_done_end", 32'(ia.mv_done), 32'd0);
    read_a("mv_r3", 2'd3, 8'h5A);

    // Clear of destination during LOAD wins over the move
    load_a(2'd2, 8'h77);
    start_a(2'd2, 2'd3);
    step();
    ia.clr = 4'b1000;
    step();
    ia.clr = 4'b0000;
    check("clr_dst_done", 32'(ia.mv_done), 32'd1);
    step();
    read_a("clr_dst_r3", 2'd3, 8'h00);

    // Clear of source during DRIVE does not affect the snapshot
    start_a(2'd2, 2'd1);
    ia.clr = 4'b0100;
    step();
    ia.clr = 4'b0000;
    check("snap_bus", obs_a(), 32'h77);
    step(); step();
    read_a("snap_r1", 2'd1, 8'h77);
    read_a("snap_r2", 2'd2, 8'h00);

    // Requests while busy are dropped and flagged
    start_a(2'd0, 2'd2);
    ia.oe_en = 1'b1; ia.oe_sel = 2'd1;
    ia.mv_start = 1'b1; ia.mv_src = 2'd1; ia.mv_dst = 2'd0;
    #1;
    check("busy_bus", obs_a(), 32'hCD);
    step();
    ia.oe_en = 1'b0; ia.mv_start = 1'b0;
    check("busy_err", 32'(ia.req_err), 32'd1);
    step();
    check("busy_done", 32'(ia.mv_done), 32'd1);
    step();
    check("no_second_move", 32'(ia.mv_busy), 32'd0);
    check("err_sticky", 32'(ia.req_err), 32'd1);
    read_a("busy_r2", 2'd2, 8'hCD);
    read_a("busy_r0", 2'd0, 8'hCD);
    ia.err_clr = 1'b1;
    step();
    ia.err_clr = 1'b0;
    check("err_clr", 32'(ia.req_err), 32'd0);

    // Asynchronous reset in the middle of DRIVE
    start_a(2'd0, 2'd3);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(ia.mv_busy), 32'd0);
    check("arst_done", 32'(ia.mv_done), 32'd0);
    check("arst_bus", obs_a(), 32'h0);
    step();
    check("arst_no_done", 32'(ia.mv_done), 32'd0);
    reset = 1'b0;
    read_a("arst_r0", 2'd0, 8'h00);
    read_a("arst_r1", 2'd1, 8'h00);
    read_a("arst_r2", 2'd2, 8'h00);

    // 16-bit, three-register instance
    load_b(2'd0, 16'hBEEF);
    read_b("b_direct_r0", 2'd0, 16'hBEEF);
    ib.oe_en = 1'b1; ib.oe_sel = 2'd0; ib.ld_en = 1'b1; ib.ld_sel = 2'd1;
    step();
    ib.oe_en = 1'b0; ib.ld_en = 1'b0;
    read_b("b_xfer_r1", 2'd1, 16'hBEEF);
    start_b(2'd0, 2'd2);
    check("b_mv_busy", 32'(ib.mv_busy), 32'd1);
    check("b_mv_bus", obs_b(), 32'hBEEF);
    step(); step();
    check("b_mv_done", 32'(ib.mv_done), 32'd1);
    step();
    read_b("b_mv_r2", 2'd2, 16'hBEEF);

    // Select 3 is out of range for three registers
    load_b(2'd3, 16'h1234);
    read_b("b_oor_r0", 2'd0, 16'hBEEF);
    read_b("b_oor_r1", 2'd1, 16'hBEEF);
    read_b("b_oor_r2", 2'd2, 16'hBEEF);
    read_b("b_oor_oe", 2'd3, 16'h0000);
    start_b(2'd3, 2'd1);
    check("b_oor_src_busy", 32'(ib.mv_busy), 32'd1);
    check("b_oor_src_bus", obs_b(), 32'h0);
    step(); step();
    check("b_oor_src_done", 32'(ib.mv_done), 32'd1);
    step();
    read_b("b_oor_src_r1", 2'd1, 16'hBEEF);
    start_b(2'd0, 2'd3);
    step(); step();
    check("b_oor_dst_done", 32'(ib.mv_done), 32'd1);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
